// File: rtl/hvac_actuator_sequencer.sv
// hvac_actuator_sequencer
// Turns per-cycle heat/cold demand from the temperature controller into
// actuator drives. It enforces a minimum on-time for every run and a minimum
// off-time (lockout) after every run. The two drives are never high together.

module hvac_actuator_sequencer #(
  parameter int unsigned MIN_ON  = 4,
  parameter int unsigned MIN_OFF = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       heat,
  input  logic       cold,
  output logic       heater_en,
  output logic       cooler_en,
  output logic [1:0] state,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAT_ON = 2'd1,
    COOL_ON = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] OnLimit  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] OffLimit = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] onCnt_q, onCnt_d;
  logic [CNT_W-1:0] offCnt_q, offCnt_d;
  logic             heaterEn_q, heaterEn_d;
  logic             coolerEn_q, coolerEn_d;
  logic             fault_q, fault_d;

  logic reqH;
  logic reqC;
  logic onDone;
  logic offDone;

  // A simultaneous heat and cold request is invalid. It counts as no demand.
  assign reqH    = heat & ~cold;
  assign reqC    = cold & ~heat;
  assign onDone  = (onCnt_q >= OnLimit);
  assign offDone = (offCnt_q >= OffLimit);

  // State, dwell counters and registered outputs; reset drops everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      onCnt_q    <= '0;
      offCnt_q   <= '0;
      heaterEn_q <= 1'b0;
      coolerEn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      onCnt_q    <= onCnt_d;
      offCnt_q   <= offCnt_d;
      heaterEn_q <= heaterEn_d;
      coolerEn_q <= coolerEn_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state decision; a changeover between heating and cooling always goes through LOCKOUT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (reqH) begin
          state_d = HEAT_ON;
        end else if (reqC) begin
          state_d = COOL_ON;
        end
      end
      HEAT_ON: begin
        if (onDone && !reqH) begin
          state_d = LOCKOUT;
        end
      end
      COOL_ON: begin
        if (onDone && !reqC) begin
          state_d = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (offDone) begin
          if (reqH) begin
            state_d = HEAT_ON;
          end else if (reqC) begin
            state_d = COOL_ON;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and counter decode from the state being entered, so the drives change on the entry edge
  always_comb begin
    heaterEn_d = (state_d == HEAT_ON);
    coolerEn_d = (state_d == COOL_ON);
    fault_d    = heat & cold;

    onCnt_d  = onCnt_q;
    offCnt_d = offCnt_q;

    if ((state_d == HEAT_ON || state_d == COOL_ON) && (state_d != state_q)) begin
      onCnt_d = CntOne;
    end else if ((state_q == HEAT_ON || state_q == COOL_ON) && !onDone) begin
      onCnt_d = onCnt_q + CntOne;
    end

    if ((state_d == LOCKOUT) && (state_q != LOCKOUT)) begin
      offCnt_d = CntOne;
    end else if ((state_q == LOCKOUT) && !offDone) begin
      offCnt_d = offCnt_q + CntOne;
    end
  end

  assign heater_en = heaterEn_q;
  assign cooler_en = coolerEn_q;
  assign state     = state_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_hvac_actuator_sequencer.sv
// tb_hvac_actuator_sequencer
// Directed bench for the actuator sequencer with MIN_ON=4 and MIN_OFF=3.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the same point.

module tb_hvac_actuator_sequencer;

  logic       clk;
  logic       reset;
  logic       heat;
  logic       cold;
  logic       heater_en;
  logic       cooler_en;
  logic [1:0] state;
  logic       fault;

  int checks;
  int errors;

  hvac_actuator_sequencer #(
    .MIN_ON (4),
    .MIN_OFF(3),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .heat     (heat),
    .cold     (cold),
    .heater_en(heater_en),
    .cooler_en(cooler_en),
    .state    (state),
    .fault    (fault)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One rising edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Check all four observable outputs at once
  task automatic checkAll(input string tag, input logic h, input logic c,
                          input logic [1:0] s, input logic f);
    checkOutput({tag, ".heater_en"}, {7'd0, heater_en}, {7'd0, h});
    checkOutput({tag, ".cooler_en"}, {7'd0, cooler_en}, {7'd0, c});
    checkOutput({tag, ".state"},     {6'd0, state},     {6'd0, s});
    checkOutput({tag, ".fault"},     {7'd0, fault},     {7'd0, f});
  endtask

  // Drive exclusivity, checked on every falling edge
  always @(negedge clk) begin
    checks++;
    assert ((heater_en & cooler_en) === 1'b0)
    else begin
      errors++;
      $error("[TB] FAIL exclusivity: observed heater_en=%b cooler_en=%b expected not both 1",
             heater_en, cooler_en);
    end
  end

  // Directed stimulus sequence
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    heat   = 1'b1;
    cold   = 1'b0;

    // 1. reset holds everything low even with heat demand
    #3;
    checkAll("rst_async", 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    checkAll("rst_edge", 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    checkAll("rst_release", 1'b1, 1'b0, 2'd1, 1'b0);
    heat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("rst_run", 1'b1, 1'b0, 2'd1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("rst_lockout", 1'b0, 1'b0, 2'd3, 1'b0);
    end
    tick();
    checkAll("rst_idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // 2. one-cycle heat pulse gives exactly MIN_ON on, then MIN_OFF lockout
    heat = 1'b1;
    tick();
    heat = 1'b0;
    checkAll("pulse_on0", 1'b1, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("pulse_on", 1'b1, 1'b0, 2'd1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("pulse_lock", 1'b0, 1'b0, 2'd3, 1'b0);
    end
    tick();
    checkAll("pulse_idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // 3. heat held 10 cycles keeps the heater on for 10 cycles
    heat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkAll("hold_on", 1'b1, 1'b0, 2'd1, 1'b0);
    end
    heat = 1'b0;
    tick();
    checkAll("hold_drop", 1'b0, 1'b0, 2'd3, 1'b0);
    tick();
    tick();
    checkAll("hold_lock3", 1'b0, 1'b0, 2'd3, 1'b0);
    tick();
    checkAll("hold_idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // 4. heat then cold: cold waits out the run and the lockout
    heat = 1'b1;
    tick();
    checkAll("chg_heat0", 1'b1, 1'b0, 2'd1, 1'b0);
    heat = 1'b0;
    cold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("chg_heat", 1'b1, 1'b0, 2'd1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("chg_lock", 1'b0, 1'b0, 2'd3, 1'b0);
    end
    tick();
    checkAll("chg_cool", 1'b0, 1'b1, 2'd2, 1'b0);
    cold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("chg_cool_run", 1'b0, 1'b1, 2'd2, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("chg_lock2", 1'b0, 1'b0, 2'd3, 1'b0);
    end
    tick();
    checkAll("chg_idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // 5. invalid heat+cold in IDLE: fault pulses, drives stay off
    heat = 1'b1;
    cold = 1'b1;
    tick();
    checkAll("inv_1", 1'b0, 1'b0, 2'd0, 1'b1);
    tick();
    checkAll("inv_2", 1'b0, 1'b0, 2'd0, 1'b1);
    heat = 1'b0;
    cold = 1'b0;
    tick();
    checkAll("inv_clear", 1'b0, 1'b0, 2'd0, 1'b0);

    // 6. reset mid-COOL_ON drops the cooler at once; no lockout afterwards
    cold = 1'b1;
    tick();
    checkAll("mid_cool", 1'b0, 1'b1, 2'd2, 1'b0);
    cold = 1'b0;
    tick();
    checkAll("mid_cool2", 1'b0, 1'b1, 2'd2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkAll("mid_rst", 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cold  = 1'b1;
    tick();
    checkAll("mid_restart", 1'b0, 1'b1, 2'd2, 1'b0);
    cold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkAll("mid_run", 1'b0, 1'b1, 2'd2, 1'b0);
    end
    tick();
    checkAll("mid_lock", 1'b0, 1'b0, 2'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
